seq_divider: RTL and testbench

Multi-cycle restoring divider: the inverse of the 4x4 combinational multiplier. It takes an 8-bit dividend, such as a product p, and a 4-bit divisor, and produces quotient and remainder over DVD_W iterations, one quotient bit per clock. It uses a start/busy/done handshake so a bench or control FSM can recover the original operand, for example a = p / b, and check p == q*b + r.

---
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing one quotient bit per clock.
// A start/busy/done handshake frames each operation; a zero divisor completes
// immediately with an all-ones quotient and the div_by_zero flag raised.
module seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [DVD_W-1:0] r_d;
  logic [DVS_W-1:0] r_dvs;
  // The partial remainder is always below the divisor between steps, so only
  // its low DVS_W bits are ever meaningful; the extra bit lives only in w_t.
  logic [DVS_W-1:0] r_r;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [DVS_W:0]   w_t;
  logic             w_ge;
  logic [DVS_W-1:0] w_sub;
  logic [DVS_W-1:0] w_rnext;
  logic [DVD_W-1:0] w_dnext;
  logic             w_last;

  // One restoring step: shift in the next dividend bit, trial-subtract, and
  // shift the resulting quotient bit into the bottom of the dividend register.
  // When T >= divisor the true difference is below the divisor, so a DVS_W-bit
  // modular subtraction gives the exact result.
  always_comb begin
    w_t     = {r_r, r_d[DVD_W-1]};
    w_ge    = (w_t >= {1'b0, r_dvs});
    w_sub   = w_t[DVS_W-1:0] - r_dvs;
    w_rnext = w_ge ? w_sub : w_t[DVS_W-1:0];
    w_dnext = {r_d[DVD_W-2:0], w_ge};
    w_last  = (r_cnt == CNT_W'(DVD_W - 1));
  end

  // Control FSM and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d     <= '0;
      r_dvs   <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              r_d     <= dividend;
              r_dvs   <= divisor;
              r_r     <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
              r_state <= S_CALC;
            end else begin
              r_quot  <= {DVD_W{1'b1}};
              r_rem   <= '0;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_d   <= w_dnext;
          r_r   <= w_rnext;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot  <= w_dnext;
            r_rem   <= w_rnext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider using an arithmetic
// reference model (plain / and %) plus handshake timing checks.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int totalCount;
  int badCount;

  seq_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalCount++;
    if (observed != expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: the arithmetic meaning of the divider.
  function automatic int refQuot(input int a, input int b);
    return (b == 0) ? 255 : (a / b);
  endfunction

  function automatic int refRem(input int a, input int b);
    return (b == 0) ? 0 : (a % b);
  endfunction

  // Issue one operation, wait for done, and report latency and busy cycles.
  // The edge that accepts start is counted as cycle 1.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) start = 1'b0;
      if (busy) busyCycles++;
      if (done) break;
    end
    if (!done) checkOutput("doneTimeout", 0, 1);
  endtask

  // Run one operation and compare it with the model; step one more edge so
  // the divider is back in IDLE before the next operation.
  task automatic runAndCheck(input string tag, input logic [7:0] a, input logic [3:0] b,
                             input bit checkTiming);
    int cycles;
    int busyCycles;
    applyStimulus(a, b, cycles, busyCycles);
    checkOutput({tag, ".q"}, int'(quotient), refQuot(int'(a), int'(b)));
    checkOutput({tag, ".r"}, int'(remainder), refRem(int'(a), int'(b)));
    checkOutput({tag, ".dbz"}, int'(div_by_zero), (b == 0) ? 1 : 0);
    if (checkTiming) begin
      checkOutput({tag, ".latency"}, cycles, (b == 0) ? 1 : 9);
      checkOutput({tag, ".busyCycles"}, busyCycles, (b == 0) ? 0 : 8);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".doneDrop"}, int'(done), 0);
  endtask

  initial begin
    int doneCount;
    int q;
    int r;
    logic [7:0] ra;
    logic [3:0] rb;

    totalCount = 0;
    badCount   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.q", int'(quotient), 0);
    checkOutput("reset.r", int'(remainder), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations, including timing of the handshake.
    runAndCheck("d195_13", 8'd195, 4'd13, 1'b1);
    runAndCheck("d200_7", 8'd200, 4'd7, 1'b1);

    // Results must hold while idle even if the operand inputs wander.
    @(negedge clk);
    dividend = 8'd17;
    divisor  = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold.q", int'(quotient), 28);
    checkOutput("hold.r", int'(remainder), 4);

    runAndCheck("d255_1", 8'd255, 4'd1, 1'b1);
    runAndCheck("d0_9", 8'd0, 4'd9, 1'b1);
    runAndCheck("d5_0", 8'd5, 4'd0, 1'b1);
    runAndCheck("d9_3", 8'd9, 4'd3, 1'b1);

    // A second start and operand change mid-operation must be ignored.
    doneCount = 0;
    q = 0;
    r = 0;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        q = int'(quotient);
        r = int'(remainder);
      end
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
      end
      if (n == 4) start = 1'b0;
    end
    checkOutput("ignore.doneCount", doneCount, 1);
    checkOutput("ignore.q", q, 33);
    checkOutput("ignore.r", r, 1);

    // Reset in the middle of a calculation abandons it without a done pulse.
    doneCount = 0;
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd2;
    start    = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
      if (n == 1) start = 1'b0;
      if (n == 3) rst = 1'b1;
    end
    checkOutput("midRst.q", int'(quotient), 0);
    checkOutput("midRst.r", int'(remainder), 0);
    checkOutput("midRst.busy", int'(busy), 0);
    checkOutput("midRst.done", int'(done), 0);
    checkOutput("midRst.dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midRst.noDone", doneCount, 0);
    runAndCheck("d255_2", 8'd255, 4'd2, 1'b1);

    // Exact products must divide back to the original factor.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        runAndCheck("prod", 8'(a * b), 4'(b), 1'b0);
      end
    end

    // Random dividends against nonzero divisors.
    for (int k = 0; k < 256; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(1, 15));
      runAndCheck("rand", ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
